// File: rtl/mux_bram_readback.sv
// rtl/mux_bram_readback.sv - gather N BRAM words into a vector, or bypass a direct vector
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en, start, sel        start request (accepted in IDLE with en=1), sel=1 gather / sel=0 bypass
//   base_addr, din_vec    first BRAM address of a gather, bypass vector
//   bram_en, bram_addr    BRAM read port (data returns on bram_dout one cycle later)
//   out_vec, out_valid    result vector, one-cycle update pulse
//   busy                  high while a transfer is in progress
module mux_bram_readback #(
   parameter int N      = 4,
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 start,
   input  logic                 sel,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [N*WIDTH-1:0]   din_vec,
   input  logic [WIDTH-1:0]     bram_dout,
   output logic                 bram_en,
   output logic [ADDR_W-1:0]    bram_addr,
   output logic [N*WIDTH-1:0]   out_vec,
   output logic                 out_valid,
   output logic                 busy
);

   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t               state, state_next;
   logic [CNT_W-1:0]     cnt;
   logic [ADDR_W-1:0]    base_q;
   logic [N*WIDTH-1:0]   gather, gather_next;
   logic [CNT_W-1:0]     wr_lane;
   logic                 wr_en;
   logic                 accept;

   assign accept    = (state == IDLE) && en && start;
   assign bram_en   = (state == ISSUE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   // Address is derived from the registered base and counter, so it holds
   // its last value whenever the counter and base are not moving.
   assign bram_addr = base_q + ADDR_W'(cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (en && start) state_next = sel ? ISSUE : DONE;
         ISSUE: if (cnt == LAST) state_next = DRAIN;
         DRAIN: state_next = DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Read k is issued in the ISSUE cycle with cnt=k; its data is present in
   // the following cycle, i.e. while cnt=k+1, or in DRAIN for the last read.
   always_comb begin
      wr_en       = ((state == ISSUE) && (cnt != '0)) || (state == DRAIN);
      wr_lane     = (state == DRAIN) ? LAST : (cnt - CNT_W'(1));
      gather_next = gather;
      if (wr_en) begin
         gather_next[int'(wr_lane)*WIDTH +: WIDTH] = bram_dout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         base_q  <= '0;
         gather  <= '0;
         out_vec <= '0;
      end else begin
         gather <= gather_next;
         if (accept) begin
            if (sel) begin
               base_q <= base_addr;
               cnt    <= '0;
            end else begin
               out_vec <= din_vec;
            end
         end
         if ((state == ISSUE) && (cnt != LAST)) begin
            cnt <= cnt + CNT_W'(1);
         end
         // Last word goes straight into out_vec together with the gathered lanes.
         if (state == DRAIN) begin
            out_vec <= gather_next;
         end
      end
   end

endmodule

// File: tb/tb_mux_bram_readback.sv
// tb/tb_mux_bram_readback.sv - directed-vector bench for mux_bram_readback
module tb_mux_bram_readback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en, start, sel;
   logic [7:0]  base_addr;
   logic [63:0] din_vec;
   logic [15:0] bram_dout;
   logic        bram_en;
   logic [7:0]  bram_addr;
   logic [63:0] out_vec;
   logic        out_valid, busy;

   logic        start1;
   logic [7:0]  base1;
   logic [15:0] din1, bram_dout1, out_vec1;
   logic        bram_en1, out_valid1, busy1;
   logic [7:0]  bram_addr1;

   logic [15:0] mem [0:255];
   int          vectors = 0;
   int          miscompares = 0;
   int          npulse = 0;
   int          bram_seen = 0;
   logic [63:0] last_vec;
   int          p0;

   mux_bram_readback #(.N(4), .WIDTH(16), .ADDR_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start), .sel(sel),
      .base_addr(base_addr), .din_vec(din_vec), .bram_dout(bram_dout),
      .bram_en(bram_en), .bram_addr(bram_addr), .out_vec(out_vec),
      .out_valid(out_valid), .busy(busy)
   );

   mux_bram_readback #(.N(1), .WIDTH(16), .ADDR_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start1), .sel(1'b1),
      .base_addr(base1), .din_vec(din1), .bram_dout(bram_dout1),
      .bram_en(bram_en1), .bram_addr(bram_addr1), .out_vec(out_vec1),
      .out_valid(out_valid1), .busy(busy1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bram_en)  bram_dout  <= mem[bram_addr];
      if (bram_en1) bram_dout1 <= mem[bram_addr1];
   end

   always @(negedge clk) begin
      if (out_valid) npulse++;
      if (bram_en)   bram_seen++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One sel=1 transfer with per-cycle checks; poke holds a bypass start
   // request high during the whole busy window, which must be ignored.
   task automatic gather(input string tag, input logic [7:0] base,
                         input logic [63:0] exp, input bit poke);
      logic [7:0] a;
      int p;
      p = npulse;
      sel = 1'b1; base_addr = base; start = 1'b1;
      tick();
      start = poke; sel = 1'b0; base_addr = 8'h77; din_vec = '1;
      for (int k = 0; k < 4; k++) begin
         a = base + 8'(k);
         chk($sformatf("%s en%0d", tag, k), 64'(bram_en), 64'd1);
         chk($sformatf("%s addr%0d", tag, k), 64'(bram_addr), 64'(a));
         chk($sformatf("%s hold%0d", tag, k), out_vec, last_vec);
         tick();
      end
      chk({tag, " drain en"}, 64'(bram_en), 64'd0);
      chk({tag, " drain valid"}, 64'(out_valid), 64'd0);
      start = 1'b0;
      tick();
      chk({tag, " valid"}, 64'(out_valid), 64'd1);
      chk({tag, " vec"}, out_vec, exp);
      last_vec = exp;
      tick();
      a = base + 8'd3;
      chk({tag, " idle busy"}, 64'(busy), 64'd0);
      chk({tag, " addr hold"}, 64'(bram_addr), 64'(a));
      chk({tag, " pulses"}, 64'(npulse - p), 64'd1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {8'h5A, 8'(i)};
      mem[8'h10] = 16'hAAAA; mem[8'h11] = 16'hBBBB;
      mem[8'h12] = 16'hCCCC; mem[8'h13] = 16'hDDDD;
      mem[8'hFE] = 16'h1111; mem[8'hFF] = 16'h2222;
      mem[8'h00] = 16'h3333; mem[8'h01] = 16'h4444;

      rst_n = 1'b0; en = 1'b0; start = 1'b0; sel = 1'b0;
      base_addr = '0; din_vec = '0; start1 = 1'b0; base1 = '0; din1 = '0;
      tick(); tick();
      chk("rst out_vec", out_vec, 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst bram_en", 64'(bram_en), 64'd0);
      chk("rst bram_addr", 64'(bram_addr), 64'd0);
      chk("rst out_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1; en = 1'b1;
      tick();

      // bypass
      bram_seen = 0;
      sel = 1'b0; din_vec = 64'h0004_0003_0002_0001; start = 1'b1;
      tick();
      start = 1'b0; din_vec = 64'h0;
      chk("byp valid", 64'(out_valid), 64'd1);
      chk("byp vec", out_vec, 64'h0004_0003_0002_0001);
      chk("byp busy", 64'(busy), 64'd1);
      tick();
      chk("byp valid off", 64'(out_valid), 64'd0);
      chk("byp idle", 64'(busy), 64'd0);
      chk("byp no bram", 64'(bram_seen), 64'd0);
      last_vec = 64'h0004_0003_0002_0001;

      gather("g10", 8'h10, 64'hDDDD_CCCC_BBBB_AAAA, 1'b0);
      gather("gFE", 8'hFE, 64'h4444_3333_2222_1111, 1'b0);
      gather("gbusy", 8'h10, 64'hDDDD_CCCC_BBBB_AAAA, 1'b1);

      // start with en=0 in IDLE
      p0 = npulse;
      en = 1'b0; sel = 1'b0; din_vec = '1; start = 1'b1;
      tick(); tick();
      chk("en0 busy", 64'(busy), 64'd0);
      chk("en0 vec", out_vec, last_vec);
      chk("en0 pulses", 64'(npulse - p0), 64'd0);
      start = 1'b0; en = 1'b1;
      tick();

      // reset mid-gather at t0+2
      sel = 1'b1; base_addr = 8'h20; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      p0 = npulse;
      rst_n = 1'b0;
      #1;
      chk("arst vec", out_vec, 64'd0);
      chk("arst bram_en", 64'(bram_en), 64'd0);
      chk("arst addr", 64'(bram_addr), 64'd0);
      chk("arst busy", 64'(busy), 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      chk("arst no pulse", 64'(npulse - p0), 64'd0);
      sel = 1'b0; din_vec = 64'h1234_5678_9ABC_DEF0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("post-rst valid", 64'(out_valid), 64'd1);
      chk("post-rst vec", out_vec, 64'h1234_5678_9ABC_DEF0);
      tick();

      // back-to-back with start held high
      sel = 1'b1; base_addr = 8'h10; start = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) tick();
      chk("b2b valid1", 64'(out_valid), 64'd1);
      chk("b2b vec1", out_vec, 64'hDDDD_CCCC_BBBB_AAAA);
      tick();
      chk("b2b idle", 64'(busy), 64'd0);
      tick();
      start = 1'b0;
      chk("b2b reissue en", 64'(bram_en), 64'd1);
      chk("b2b reissue addr", 64'(bram_addr), 64'h10);
      for (int k = 0; k < 5; k++) tick();
      chk("b2b valid2", 64'(out_valid), 64'd1);
      tick();

      // N=1 instance
      base1 = 8'h12; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("n1 en", 64'(bram_en1), 64'd1);
      chk("n1 addr", 64'(bram_addr1), 64'h12);
      tick();
      chk("n1 drain", 64'(out_valid1), 64'd0);
      tick();
      chk("n1 valid", 64'(out_valid1), 64'd1);
      chk("n1 vec", 64'(out_vec1), 64'hCCCC);
      tick();
      chk("n1 idle", 64'(busy1), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mux_bram_readback.md
MUX_BRAM_READBACK -- requirements
Module: mux_bram_readback

Interface
REQ-001 The block SHALL expose parameter N, default 4, number of WIDTH-bit lanes in a vector.
REQ-002 The block SHALL expose parameter WIDTH, default 16, lane width in bits.
REQ-003 The block SHALL expose parameter ADDR_W, default 8, BRAM address width.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 en  input  1  enables acceptance of start in IDLE.
REQ-008 start  input  1  request one transfer; sampled only in IDLE with en=1.
REQ-009 sel  input  1  1: gather vector from BRAM; 0: pass din_vec directly; sampled with start.
REQ-010 base_addr  input  ADDR_W  first BRAM address of the gather; sampled with start.
REQ-011 din_vec  input  N*WIDTH  direct bypass vector; sampled with start when sel=0.
REQ-012 bram_dout  input  WIDTH  BRAM read data, valid exactly 1 cycle after bram_en=1.
REQ-013 bram_en  output  1  BRAM read enable.
REQ-014 bram_addr  output  ADDR_W  BRAM read address.
REQ-015 out_vec  output  N*WIDTH  assembled/bypassed result vector.
REQ-016 out_valid  output  1  one-cycle pulse: out_vec has been updated.
REQ-017 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-019 In IDLE with en=1, start=1, sel=0: din_vec SHALL be captured into out_vec at that edge and FSM SHALL enter DONE.
REQ-020 In IDLE with en=1, start=1, sel=1: base_addr SHALL be latched, issue counter cleared, FSM SHALL enter ISSUE.
REQ-021 In ISSUE, for k=0..N-1 on consecutive cycles: bram_en=1, bram_addr=(base_addr+k) mod 2^ADDR_W; after k=N-1 FSM SHALL enter DRAIN.
REQ-022 Word returned for read k SHALL be stored into lane k, i.e. bits [k*WIDTH +: WIDTH] of an internal gather register.
REQ-023 In DRAIN the last word (k=N-1) SHALL be captured; gather register SHALL then be copied to out_vec in one step; FSM SHALL enter DONE.
REQ-024 In DONE out_valid SHALL be 1 for exactly one cycle; FSM SHALL return to IDLE next edge.
REQ-025 Latency: start accepted at edge t0; sel=0 -> out_valid high in cycle t0+1; sel=1 -> bram_en high cycles t0+1..t0+N, out_valid high in cycle t0+N+2.
REQ-026 out_vec SHALL change only on entry to DONE and SHALL hold its value otherwise, including while busy.
REQ-027 bram_en SHALL be 0 outside ISSUE; bram_addr SHALL hold its last value when bram_en=0.
REQ-028 start SHALL be ignored while busy=1 and in IDLE when en=0; no queuing.
REQ-029 Once started, a transfer SHALL complete regardless of en, sel, start, base_addr changes.
REQ-030 Back-to-back: start held high SHALL be accepted again in the IDLE cycle following DONE.
REQ-031 Address wrap: base_addr near 2^ADDR_W-1 SHALL wrap to 0 without error.
REQ-032 N=1 SHALL work: one read cycle, out_valid at t0+3.

Reset
REQ-033 On rst_n=0, asynchronously: FSM=IDLE, bram_en=0, bram_addr=0, out_vec=0, out_valid=0, busy=0, gather register=0, counter=0.
REQ-034 Reset mid-transfer SHALL abort it; no out_valid SHALL follow; first start after rst_n rises SHALL be accepted normally.

Verification
REQ-035 sel=0, din_vec=64'h0004_0003_0002_0001, start pulse -> out_vec=64'h0004_0003_0002_0001, out_valid one cycle at t0+1, bram_en never high.
REQ-036 sel=1, base_addr=8'h10, BRAM[0x10..0x13]=AAAA,BBBB,CCCC,DDDD -> addresses 10,11,12,13 on cycles t0+1..t0+4, out_vec=64'hDDDD_CCCC_BBBB_AAAA, out_valid at t0+6.
REQ-037 sel=1, base_addr=8'hFE -> bram_addr sequence FE,FF,00,01; lanes filled in that order.
REQ-038 start pulses during busy and with en=0 in IDLE -> ignored; out_vec unchanged; only one out_valid per accepted start.
REQ-039 rst_n low at cycle t0+2 of a gather -> all outputs 0 immediately; no out_valid; subsequent sel=0 transfer completes correctly.
REQ-040 start held high continuously, sel=1 -> consecutive gathers with one IDLE cycle between DONE and next ISSUE.
